dec_exe_stage_reg: RTL and testbench

- Decode-to-execute pipeline register that consumes the bypass controller's outputs.
- Selects each source operand from either the bypass data or the register-file read data, then latches the instruction into the execute stage.
- Inserts a bubble when the bypass controller signals a hazard stall.
- Holds its contents on execute back-pressure and squashes on flush; generates the decode/fetch hold signal.

---
 rtl/dec_exe_stage_reg.sv | 136 +++++++++++++
 tb/tb_dec_exe_stage_reg.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_exe_stage_reg.sv
// Decode-to-execute pipeline register: operand bypass select, hazard bubbles, back-pressure hold, flush.
// Optional saturating hazard-stall counter enabled with `define DEC_EXE_STALL_PERF_EN.
module dec_exe_stage_reg #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ALU_OP_W = 4,
  parameter int unsigned PERF_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                dec_valid_i,
  input  logic [XLEN-1:0]     dec_pc_i,
  input  logic [4:0]          dec_read_addr_a_i,
  input  logic [4:0]          dec_read_addr_b_i,
  input  logic [XLEN-1:0]     rf_data_a_i,
  input  logic [XLEN-1:0]     rf_data_b_i,
  input  logic [XLEN-1:0]     dec_imm_i,
  input  logic [4:0]          dec_dest_addr_i,
  input  logic                dec_wr_en_i,
  input  logic                dec_is_load_i,
  input  logic                dec_is_mult_i,
  input  logic [ALU_OP_W-1:0] dec_alu_op_i,
  input  logic                bypass_a_en_i,
  input  logic                bypass_b_en_i,
  input  logic [XLEN-1:0]     bypass_data_a_i,
  input  logic [XLEN-1:0]     bypass_data_b_i,
  input  logic                stall_core_i,
  input  logic                exe_stall_i,
  input  logic                flush_i,
  output logic                exe_valid_o,
  output logic [XLEN-1:0]     exe_pc_o,
  output logic [XLEN-1:0]     exe_data_a_o,
  output logic [XLEN-1:0]     exe_data_b_o,
  output logic [XLEN-1:0]     exe_imm_o,
  output logic [4:0]          exe_addr_o,
  output logic                exe_wr_en_o,
  output logic                exe_is_load_o,
  output logic                exe_is_mult_o,
  output logic [ALU_OP_W-1:0] exe_alu_op_o,
  output logic                dec_hold_o
`ifdef DEC_EXE_STALL_PERF_EN
  ,
  output logic [PERF_W-1:0]   stall_cycles_o
`endif
);

  if (PERF_W < 1) begin : g_bad_perf_w
    $error("PERF_W must be at least 1");
  end

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            bubble;
  logic            load_en;

  // x0 always reads as zero, even if the bypass controller claims a forward for it.
  always_comb begin
    op_a = '0;
    if (dec_read_addr_a_i != 5'd0) begin
      op_a = bypass_a_en_i ? bypass_data_a_i : rf_data_a_i;
    end
  end

  always_comb begin
    op_b = '0;
    if (dec_read_addr_b_i != 5'd0) begin
      op_b = bypass_b_en_i ? bypass_data_b_i : rf_data_b_i;
    end
  end

  assign bubble     = stall_core_i & dec_valid_i;
  assign load_en    = ~flush_i & ~exe_stall_i & ~bubble;
  assign dec_hold_o = dec_valid_i & ~flush_i & (exe_stall_i | stall_core_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exe_valid_o   <= 1'b0;
      exe_wr_en_o   <= 1'b0;
      exe_is_load_o <= 1'b0;
      exe_is_mult_o <= 1'b0;
    end else if (flush_i) begin
      exe_valid_o   <= 1'b0;
      exe_wr_en_o   <= 1'b0;
      exe_is_load_o <= 1'b0;
      exe_is_mult_o <= 1'b0;
    end else if (exe_stall_i) begin
      exe_valid_o   <= exe_valid_o;
      exe_wr_en_o   <= exe_wr_en_o;
      exe_is_load_o <= exe_is_load_o;
      exe_is_mult_o <= exe_is_mult_o;
    end else if (bubble) begin
      exe_valid_o   <= 1'b0;
      exe_wr_en_o   <= 1'b0;
      exe_is_load_o <= 1'b0;
      exe_is_mult_o <= 1'b0;
    end else begin
      exe_valid_o   <= dec_valid_i;
      exe_wr_en_o   <= dec_wr_en_i & dec_valid_i;
      exe_is_load_o <= dec_is_load_i & dec_valid_i;
      exe_is_mult_o <= dec_is_mult_i & dec_valid_i;
    end
  end

  // Data fields only move on a real capture; bubbles and flushes leave them untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exe_pc_o     <= '0;
      exe_data_a_o <= '0;
      exe_data_b_o <= '0;
      exe_imm_o    <= '0;
      exe_addr_o   <= '0;
      exe_alu_op_o <= '0;
    end else if (load_en) begin
      exe_pc_o     <= dec_pc_i;
      exe_data_a_o <= op_a;
      exe_data_b_o <= op_b;
      exe_imm_o    <= dec_imm_i;
      exe_addr_o   <= dec_dest_addr_i;
      exe_alu_op_o <= dec_alu_op_i;
    end
  end

`ifdef DEC_EXE_STALL_PERF_EN
  logic perf_inc;

  assign perf_inc = dec_valid_i & stall_core_i & ~exe_stall_i & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_o <= '0;
    end else if (perf_inc && (stall_cycles_o != {PERF_W{1'b1}})) begin
      stall_cycles_o <= stall_cycles_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dec_exe_stage_reg.sv
// Self-checking bench for dec_exe_stage_reg: vector table plus hand-written multi-cycle sequences.
module tb_dec_exe_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] rfa;
    logic [31:0] rfb;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        wr;
    logic        ld;
    logic        mul;
    logic [3:0]  op;
    logic        baEn;
    logic        bbEn;
    logic [31:0] bda;
    logic [31:0] bdb;
    logic        stallCore;
    logic        exeStall;
    logic        flush;
    logic        chkData;
    logic        expHold;
    logic        expValid;
    logic [31:0] expPc;
    logic [31:0] expA;
    logic [31:0] expB;
    logic [31:0] expImm;
    logic [4:0]  expAddr;
    logic        expWr;
    logic        expLd;
    logic        expMul;
    logic [3:0]  expOp;
  } vec_t;

  localparam int NumVecs = 7;

  logic        clk_i;
  logic        rst_i;
  logic        dec_valid_i;
  logic [31:0] dec_pc_i;
  logic [4:0]  dec_read_addr_a_i;
  logic [4:0]  dec_read_addr_b_i;
  logic [31:0] rf_data_a_i;
  logic [31:0] rf_data_b_i;
  logic [31:0] dec_imm_i;
  logic [4:0]  dec_dest_addr_i;
  logic        dec_wr_en_i;
  logic        dec_is_load_i;
  logic        dec_is_mult_i;
  logic [3:0]  dec_alu_op_i;
  logic        bypass_a_en_i;
  logic        bypass_b_en_i;
  logic [31:0] bypass_data_a_i;
  logic [31:0] bypass_data_b_i;
  logic        stall_core_i;
  logic        exe_stall_i;
  logic        flush_i;
  logic        exe_valid_o;
  logic [31:0] exe_pc_o;
  logic [31:0] exe_data_a_o;
  logic [31:0] exe_data_b_o;
  logic [31:0] exe_imm_o;
  logic [4:0]  exe_addr_o;
  logic        exe_wr_en_o;
  logic        exe_is_load_o;
  logic        exe_is_mult_o;
  logic [3:0]  exe_alu_op_o;
  logic        dec_hold_o;
`ifdef DEC_EXE_STALL_PERF_EN
  logic [1:0]  stall_cycles_o;
`endif

  int   checks;
  int   errors;
  vec_t vecs [NumVecs];

  dec_exe_stage_reg #(
    .XLEN     (32),
    .ALU_OP_W (4),
`ifdef DEC_EXE_STALL_PERF_EN
    .PERF_W   (2)
`else
    .PERF_W   (16)
`endif
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .dec_valid_i       (dec_valid_i),
    .dec_pc_i          (dec_pc_i),
    .dec_read_addr_a_i (dec_read_addr_a_i),
    .dec_read_addr_b_i (dec_read_addr_b_i),
    .rf_data_a_i       (rf_data_a_i),
    .rf_data_b_i       (rf_data_b_i),
    .dec_imm_i         (dec_imm_i),
    .dec_dest_addr_i   (dec_dest_addr_i),
    .dec_wr_en_i       (dec_wr_en_i),
    .dec_is_load_i     (dec_is_load_i),
    .dec_is_mult_i     (dec_is_mult_i),
    .dec_alu_op_i      (dec_alu_op_i),
    .bypass_a_en_i     (bypass_a_en_i),
    .bypass_b_en_i     (bypass_b_en_i),
    .bypass_data_a_i   (bypass_data_a_i),
    .bypass_data_b_i   (bypass_data_b_i),
    .stall_core_i      (stall_core_i),
    .exe_stall_i       (exe_stall_i),
    .flush_i           (flush_i),
    .exe_valid_o       (exe_valid_o),
    .exe_pc_o          (exe_pc_o),
    .exe_data_a_o      (exe_data_a_o),
    .exe_data_b_o      (exe_data_b_o),
    .exe_imm_o         (exe_imm_o),
    .exe_addr_o        (exe_addr_o),
    .exe_wr_en_o       (exe_wr_en_o),
    .exe_is_load_o     (exe_is_load_o),
    .exe_is_mult_o     (exe_is_mult_o),
    .exe_alu_op_o      (exe_alu_op_o),
    .dec_hold_o        (dec_hold_o)
`ifdef DEC_EXE_STALL_PERF_EN
    ,
    .stall_cycles_o    (stall_cycles_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clearInputs();
    dec_valid_i       = 1'b0;
    dec_pc_i          = '0;
    dec_read_addr_a_i = '0;
    dec_read_addr_b_i = '0;
    rf_data_a_i       = '0;
    rf_data_b_i       = '0;
    dec_imm_i         = '0;
    dec_dest_addr_i   = '0;
    dec_wr_en_i       = 1'b0;
    dec_is_load_i     = 1'b0;
    dec_is_mult_i     = 1'b0;
    dec_alu_op_i      = '0;
    bypass_a_en_i     = 1'b0;
    bypass_b_en_i     = 1'b0;
    bypass_data_a_i   = '0;
    bypass_data_b_i   = '0;
    stall_core_i      = 1'b0;
    exe_stall_i       = 1'b0;
    flush_i           = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    dec_valid_i       = v.valid;
    dec_pc_i          = v.pc;
    dec_read_addr_a_i = v.ra;
    dec_read_addr_b_i = v.rb;
    rf_data_a_i       = v.rfa;
    rf_data_b_i       = v.rfb;
    dec_imm_i         = v.imm;
    dec_dest_addr_i   = v.dest;
    dec_wr_en_i       = v.wr;
    dec_is_load_i     = v.ld;
    dec_is_mult_i     = v.mul;
    dec_alu_op_i      = v.op;
    bypass_a_en_i     = v.baEn;
    bypass_b_en_i     = v.bbEn;
    bypass_data_a_i   = v.bda;
    bypass_data_b_i   = v.bdb;
    stall_core_i      = v.stallCore;
    exe_stall_i       = v.exeStall;
    flush_i           = v.flush;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " valid"}, 32'(exe_valid_o), 32'd0);
    checkOutput({tag, " pc"}, exe_pc_o, 32'd0);
    checkOutput({tag, " data_a"}, exe_data_a_o, 32'd0);
    checkOutput({tag, " data_b"}, exe_data_b_o, 32'd0);
    checkOutput({tag, " imm"}, exe_imm_o, 32'd0);
    checkOutput({tag, " addr"}, 32'(exe_addr_o), 32'd0);
    checkOutput({tag, " flags"}, {29'd0, exe_wr_en_o, exe_is_load_o, exe_is_mult_o}, 32'd0);
    checkOutput({tag, " alu_op"}, 32'(exe_alu_op_o), 32'd0);
  endtask

  // Drive at the falling edge, check the hold output there, then check the register just after the rising edge.
  task automatic stepAndCheck(input string tag, input vec_t v);
    @(negedge clk_i);
    applyStimulus(v);
    #1;
    checkOutput({tag, " hold"}, 32'(dec_hold_o), 32'(v.expHold));
    @(posedge clk_i);
    #1;
    checkOutput({tag, " valid"}, 32'(exe_valid_o), 32'(v.expValid));
    checkOutput({tag, " flags"}, {29'd0, exe_wr_en_o, exe_is_load_o, exe_is_mult_o},
                {29'd0, v.expWr, v.expLd, v.expMul});
    if (v.chkData) begin
      checkOutput({tag, " pc"}, exe_pc_o, v.expPc);
      checkOutput({tag, " data_a"}, exe_data_a_o, v.expA);
      checkOutput({tag, " data_b"}, exe_data_b_o, v.expB);
      checkOutput({tag, " imm"}, exe_imm_o, v.expImm);
      checkOutput({tag, " addr"}, 32'(exe_addr_o), 32'(v.expAddr));
      checkOutput({tag, " alu_op"}, 32'(exe_alu_op_o), 32'(v.expOp));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    for (int i = 0; i < NumVecs; i++) vecs[i] = '0;

    // Plain capture after reset.
    vecs[0].valid = 1; vecs[0].pc = 32'h100; vecs[0].ra = 3; vecs[0].rfa = 32'h11;
    vecs[0].rb = 4; vecs[0].rfb = 32'h22; vecs[0].imm = 32'h5; vecs[0].dest = 7;
    vecs[0].wr = 1; vecs[0].op = 4'd2; vecs[0].chkData = 1;
    vecs[0].expValid = 1; vecs[0].expPc = 32'h100; vecs[0].expA = 32'h11; vecs[0].expB = 32'h22;
    vecs[0].expImm = 32'h5; vecs[0].expAddr = 7; vecs[0].expWr = 1; vecs[0].expOp = 4'd2;

    // Bypass wins over the register file; x0 forces zero despite a bypass.
    vecs[1].valid = 1; vecs[1].pc = 32'h104; vecs[1].ra = 5; vecs[1].rfa = 32'h1;
    vecs[1].baEn = 1; vecs[1].bda = 32'hDEAD; vecs[1].rb = 0; vecs[1].rfb = 32'h33;
    vecs[1].bbEn = 1; vecs[1].bdb = 32'hBEEF; vecs[1].imm = 32'h8; vecs[1].dest = 9;
    vecs[1].wr = 1; vecs[1].ld = 1; vecs[1].op = 4'd3; vecs[1].chkData = 1;
    vecs[1].expValid = 1; vecs[1].expPc = 32'h104; vecs[1].expA = 32'hDEAD; vecs[1].expB = 32'h0;
    vecs[1].expImm = 32'h8; vecs[1].expAddr = 9; vecs[1].expWr = 1; vecs[1].expLd = 1; vecs[1].expOp = 4'd3;

    // Invalid decode: hazard stall ignored, flags gated off, data still captured.
    vecs[2].valid = 0; vecs[2].pc = 32'h108; vecs[2].ra = 1; vecs[2].rfa = 32'h55;
    vecs[2].rb = 2; vecs[2].rfb = 32'h66; vecs[2].bbEn = 1; vecs[2].bdb = 32'h77;
    vecs[2].imm = 32'h9; vecs[2].dest = 3; vecs[2].wr = 1; vecs[2].mul = 1; vecs[2].op = 4'd4;
    vecs[2].stallCore = 1; vecs[2].chkData = 1;
    vecs[2].expPc = 32'h108; vecs[2].expA = 32'h55; vecs[2].expB = 32'h77;
    vecs[2].expImm = 32'h9; vecs[2].expAddr = 3; vecs[2].expOp = 4'd4;

    // Multiply with source A = x0.
    vecs[3].valid = 1; vecs[3].pc = 32'h10C; vecs[3].ra = 0; vecs[3].rfa = 32'h99;
    vecs[3].rb = 6; vecs[3].rfb = 32'h44; vecs[3].imm = 32'hA; vecs[3].dest = 4;
    vecs[3].mul = 1; vecs[3].op = 4'd5; vecs[3].chkData = 1;
    vecs[3].expValid = 1; vecs[3].expPc = 32'h10C; vecs[3].expA = 32'h0; vecs[3].expB = 32'h44;
    vecs[3].expImm = 32'hA; vecs[3].expAddr = 4; vecs[3].expMul = 1; vecs[3].expOp = 4'd5;

    // Back-pressure: new decode is ignored, register holds.
    vecs[4].valid = 1; vecs[4].pc = 32'h200; vecs[4].ra = 1; vecs[4].rfa = 32'h1234;
    vecs[4].rb = 2; vecs[4].rfb = 32'h5678; vecs[4].imm = 32'hF; vecs[4].dest = 12;
    vecs[4].wr = 1; vecs[4].op = 4'd7; vecs[4].exeStall = 1; vecs[4].chkData = 1;
    vecs[4].expHold = 1; vecs[4].expValid = 1; vecs[4].expPc = 32'h10C; vecs[4].expA = 32'h0;
    vecs[4].expB = 32'h44; vecs[4].expImm = 32'hA; vecs[4].expAddr = 4; vecs[4].expMul = 1; vecs[4].expOp = 4'd5;

    // Flush beats both stalls.
    vecs[5].valid = 1; vecs[5].pc = 32'h204; vecs[5].wr = 1; vecs[5].ld = 1; vecs[5].mul = 1;
    vecs[5].exeStall = 1; vecs[5].stallCore = 1; vecs[5].flush = 1;

    // Hazard bubble.
    vecs[6].valid = 1; vecs[6].pc = 32'h208; vecs[6].wr = 1; vecs[6].ld = 1;
    vecs[6].stallCore = 1; vecs[6].expHold = 1;

    clearInputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checkAllZero("reset");
    checkOutput("reset hold", 32'(dec_hold_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < NumVecs; i++) begin
      stepAndCheck($sformatf("vec%0d", i), vecs[i]);
    end

    // Two-cycle hazard stall, then exactly one capture.
    @(negedge clk_i);
    clearInputs();
    dec_valid_i = 1; dec_pc_i = 32'h300; dec_read_addr_a_i = 2; rf_data_a_i = 32'h70;
    dec_wr_en_i = 1; stall_core_i = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checkOutput($sformatf("bubble%0d hold", c), 32'(dec_hold_o), 32'd1);
      @(posedge clk_i);
      #1;
      checkOutput($sformatf("bubble%0d valid", c), 32'(exe_valid_o), 32'd0);
      checkOutput($sformatf("bubble%0d wr", c), 32'(exe_wr_en_o), 32'd0);
      @(negedge clk_i);
    end
    stall_core_i = 0;
    #1;
    checkOutput("release hold", 32'(dec_hold_o), 32'd0);
    @(posedge clk_i);
    #1;
    checkOutput("release valid", 32'(exe_valid_o), 32'd1);
    checkOutput("release wr", 32'(exe_wr_en_o), 32'd1);
    checkOutput("release pc", exe_pc_o, 32'h300);
    checkOutput("release data_a", exe_data_a_o, 32'h70);
    @(negedge clk_i);
    dec_valid_i = 0;
    @(posedge clk_i);
    #1;
    checkOutput("once valid", 32'(exe_valid_o), 32'd0);

    // Back-pressure for three cycles while source data keeps changing.
    @(negedge clk_i);
    clearInputs();
    dec_valid_i = 1; dec_pc_i = 32'h200; dec_read_addr_a_i = 1; rf_data_a_i = 32'hAA;
    dec_read_addr_b_i = 2; bypass_b_en_i = 1; bypass_data_b_i = 32'hBB; dec_wr_en_i = 1;
    @(posedge clk_i);
    #1;
    checkOutput("bp load pc", exe_pc_o, 32'h200);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      exe_stall_i = 1;
      dec_pc_i = 32'h400 + 32'(c * 4);
      rf_data_a_i = 32'h1000 + 32'(c);
      bypass_data_b_i = 32'h2000 + 32'(c);
      #1;
      checkOutput($sformatf("bp%0d hold", c), 32'(dec_hold_o), 32'd1);
      @(posedge clk_i);
      #1;
      checkOutput($sformatf("bp%0d pc", c), exe_pc_o, 32'h200);
      checkOutput($sformatf("bp%0d data_a", c), exe_data_a_o, 32'hAA);
      checkOutput($sformatf("bp%0d data_b", c), exe_data_b_o, 32'hBB);
      checkOutput($sformatf("bp%0d valid", c), 32'(exe_valid_o), 32'd1);
    end

    // Synchronous reset while back-pressure is still asserted.
    @(negedge clk_i);
    rst_i = 1;
    @(posedge clk_i);
    #1;
    checkAllZero("midstall reset");
    @(negedge clk_i);
    rst_i = 0;
    clearInputs();

`ifdef DEC_EXE_STALL_PERF_EN
    // Two-bit counter saturates at 3.
    dec_valid_i = 1; stall_core_i = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i);
      #1;
      checkOutput($sformatf("perf%0d", c), 32'(stall_cycles_o), (c < 3) ? 32'(c + 1) : 32'd3);
    end
    @(negedge clk_i);
    clearInputs();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
